// File: rtl/fill_pkg.sv
// Shared encodings and geometry constants for the rectangle fill engine.
package fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DATA2 = 2'd3
    } fill_state_e;

    localparam int PIX_PER_BURST = 8;
    localparam int PIX_PER_WORD  = 4;
    localparam int BYTES_PER_PIX = 4;

    localparam logic [15:0] MASK_ALL  = 16'hFFFF;
    localparam logic [15:0] MASK_NONE = 16'h0000;

endpackage

// File: rtl/rect_fill_mask.sv
// Byte write mask for one 4-pixel word: a pixel outside [x0,x1] gets its whole nibble set.
module rect_fill_mask
    import fill_pkg::*;
#(
    parameter int X_W = 10
) (
    input  logic [X_W-1:0] base_i,
    input  logic [X_W-1:0] x0_i,
    input  logic [X_W-1:0] x1_i,
    output logic [15:0]    mask_o
);

    logic [X_W:0] col;

    // One extra bit on the column so base+k cannot wrap at the top of the range.
    always_comb begin
        mask_o = MASK_NONE;
        col    = '0;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            col = {1'b0, base_i} + (X_W+1)'(k);
            if (col < {1'b0, x0_i} || col > {1'b0, x1_i})
                mask_o[k*BYTES_PER_PIX +: BYTES_PER_PIX] = '1;
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Fills an inclusive rectangle of a frame buffer with one colour as 8-pixel DDR2 bursts
// (one address push followed by two masked 128-bit data words).
module rect_fill_engine
    import fill_pkg::*;
#(
    parameter int FRAME_W = 800,
    parameter int FRAME_H = 600,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int ADDR_W  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [23:0]       color,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    y1,
    input  logic [5:0]        frame_id,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic              af_wr_en,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              wdf_wr_en,
    output logic [127:0]      wdf_din,
    output logic [15:0]       wdf_mask_din,
    output logic              ready,
    output logic              done
);

    localparam logic [X_W-1:0] X_MAX   = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(FRAME_H - 1);
    localparam logic [X_W-1:0] BURST_M = ~X_W'(PIX_PER_BURST - 1);
    localparam int             USED_W  = 6 + Y_W + (X_W - 3) + 2;

    fill_state_e    state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           done_q, done_d;

    logic [X_W-1:0] x0_q, x1_q;
    logic [Y_W-1:0] y0_q, y1_q;
    logic [23:0]    color_q;
    logic [5:0]     frame_q;

    logic [X_W-1:0] x0_al, x1_al, word_base;
    logic [15:0]    word_mask;

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign x0_al = x0_q & BURST_M;
    assign x1_al = x1_q & BURST_M;

    // Command registers; far bounds are clipped to the frame so bursts never leave it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            frame_q <= '0;
        end else if (valid && ready) begin
            x0_q    <= x0;
            x1_q    <= (x1 > X_MAX) ? X_MAX : x1;
            y0_q    <= y0;
            y1_q    <= (y1 > Y_MAX) ? Y_MAX : y1;
            color_q <= color;
            frame_q <= frame_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        af_wr_en  = 1'b0;
        wdf_wr_en = 1'b0;
        unique case (state_q)
            IDLE: if (valid) state_d = CHECK;
            CHECK: begin
                if (x0_q > x1_q || y0_q > y1_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d     = x0_al;
                    y_d     = y0_q;
                    state_d = REQ;
                end
            end
            // Address and word 0 go together so a burst is never split across stalls.
            REQ: begin
                af_wr_en  = !af_full && !wdf_full;
                wdf_wr_en = af_wr_en;
                if (af_wr_en) state_d = DATA2;
            end
            DATA2: begin
                wdf_wr_en = !wdf_full;
                if (wdf_wr_en) begin
                    state_d = REQ;
                    if (x_q == x1_al) begin
                        if (y_q == y1_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            x_d = x0_al;
                            y_d = y_q + Y_W'(1);
                        end
                    end else begin
                        x_d = x_q + X_W'(PIX_PER_BURST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_base = x_q + ((state_q == DATA2) ? X_W'(PIX_PER_WORD) : '0);

    rect_fill_mask #(.X_W(X_W)) u_mask (
        .base_i (word_base),
        .x0_i   (x0_q),
        .x1_i   (x1_q),
        .mask_o (word_mask)
    );

    assign wdf_mask_din = (state_q == REQ || state_q == DATA2) ? word_mask : MASK_ALL;
    assign wdf_din      = {PIX_PER_WORD{{8'h00, color_q}}};
    assign af_addr_din  = {{(ADDR_W-USED_W){1'b0}}, frame_q, y_q, x_q[X_W-1:3], 2'b00};

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine against a burst-list reference model.
module tb_rect_fill_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [23:0]  color = '0;
    logic [9:0]   x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic [5:0]   frame_id = '0;
    logic         af_full = 1'b0, wdf_full = 1'b0;
    logic         af_wr_en, wdf_wr_en, ready, done;
    logic [30:0]  af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    always #5 clk = ~clk;

    rect_fill_engine #(.FRAME_W(800), .FRAME_H(600), .X_W(10), .Y_W(10), .ADDR_W(31)) dut (
        .clk(clk), .rst(rst), .valid(valid), .color(color),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .frame_id(frame_id),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_wr_en(af_wr_en), .af_addr_din(af_addr_din),
        .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
        .ready(ready), .done(done)
    );

    int n_checks = 0, n_fail = 0;
    int done_cnt = 0, viol_full = 0, viol_pair = 0, viol_stable = 0;
    bit bp_en = 1'b0;

    logic [30:0]  exp_addr[$], obs_addr[$];
    logic [127:0] exp_data[$], obs_data[$];
    logic [15:0]  exp_mask[$], obs_mask[$];

    int rx0[12], rx1[12], ry0[12], ry1[12], rfid[12];
    logic [23:0] rcol[12];

    // Random FIFO-full backpressure, changed just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        af_full  = bp_en && ($urandom_range(0, 2) == 0);
        wdf_full = bp_en && ($urandom_range(0, 2) == 0);
    end

    // Push monitor: records every FIFO push and flags protocol violations.
    initial begin : mon
        bit armed, prev_push;
        int wcnt;
        logic [30:0] pa;
        logic [127:0] pd;
        logic [15:0] pm;
        armed = 0; prev_push = 0; wcnt = 0; pa = '0; pd = '0; pm = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 0; prev_push = 0; wcnt = 0;
            end else begin
                if ((af_wr_en && af_full) || (wdf_wr_en && wdf_full)) viol_full++;
                if (af_wr_en && (!wdf_wr_en || wcnt % 2 != 0)) viol_pair++;
                if (wdf_wr_en && !af_wr_en && wcnt % 2 == 0) viol_pair++;
                if (armed && !prev_push && (af_addr_din !== pa || wdf_din !== pd || wdf_mask_din !== pm))
                    viol_stable++;
                if (af_wr_en) begin obs_addr.push_back(af_addr_din); armed = 1; end
                if (wdf_wr_en) begin
                    obs_data.push_back(wdf_din);
                    obs_mask.push_back(wdf_mask_din);
                    wcnt++;
                end
                if (done === 1'b1) begin done_cnt++; armed = 0; end
                prev_push = af_wr_en || wdf_wr_en;
                pa = af_addr_din; pd = wdf_din; pm = wdf_mask_din;
            end
        end
    end

    task automatic clear_q();
        exp_addr.delete(); exp_data.delete(); exp_mask.delete();
        obs_addr.delete(); obs_data.delete(); obs_mask.delete();
    endtask

    // Expected burst list straight from the rectangle geometry.
    task automatic model_cmd(input int ax0, ax1, ay0, ay1, afid, input logic [23:0] acol);
        int cx1, cy1, c;
        logic [15:0] m;
        cx1 = (ax1 > 799) ? 799 : ax1;
        cy1 = (ay1 > 599) ? 599 : ay1;
        if (ax0 > cx1 || ay0 > cy1) return;
        for (int y = ay0; y <= cy1; y++)
            for (int bx = (ax0 / 8) * 8; bx <= cx1; bx += 8) begin
                exp_addr.push_back(31'((afid << 19) + (y << 9) + ((bx / 8) << 2)));
                for (int w = 0; w < 2; w++) begin
                    m = 16'h0000;
                    for (int k = 0; k < 4; k++) begin
                        c = bx + 4 * w + k;
                        if (c < ax0 || c > cx1) m = m | (16'hF << (4 * k));
                    end
                    exp_mask.push_back(m);
                    exp_data.push_back({4{8'h00, acol}});
                end
            end
    endtask

    function automatic int diff_count();
        int d;
        d = 0;
        if (exp_addr.size() != obs_addr.size() || exp_data.size() != obs_data.size()) d++;
        foreach (exp_addr[i]) if (i < obs_addr.size() && obs_addr[i] !== exp_addr[i]) d++;
        foreach (exp_data[i])
            if (i < obs_data.size() && (obs_data[i] !== exp_data[i] || obs_mask[i] !== exp_mask[i])) d++;
        return d;
    endfunction

    task automatic issue(input int ax0, ax1, ay0, ay1, afid, input logic [23:0] acol);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        valid = 1'b1; x0 = 10'(ax0); x1 = 10'(ax1); y0 = 10'(ay0); y1 = 10'(ay1);
        frame_id = 6'(afid); color = acol;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", tag, done, n);
        end
    endtask

    task automatic run_cmd(input string tag, input int ax0, ax1, ay0, ay1, afid, input logic [23:0] acol);
        issue(ax0, ax1, ay0, ay1, afid, acol);
        wait_done(tag);
        model_cmd(ax0, ax1, ay0, ay1, afid, acol);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ready, done, af_wr_en, wdf_wr_en, wdf_mask_din} !== {4'b1000, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy/done/af/wdf/mask=%b%b%b%b/%h, required 1000/ffff",
                     ready, done, af_wr_en, wdf_wr_en, wdf_mask_din);
        end
    endtask

    task automatic test_rect_example();
        int d0, d;
        clear_q(); d0 = done_cnt;
        run_cmd("rect", 3, 10, 5, 5, 2, 24'h123456);
        n_checks++;
        if (obs_mask.size() != 4 || {obs_mask[0], obs_mask[1], obs_mask[2], obs_mask[3]} !== 64'h0FFF_0000_F000_FFFF) begin
            n_fail++;
            $display("FAIL rect_masks: got %0d words, first=%h, required 0fff,0000,f000,ffff",
                     obs_mask.size(), (obs_mask.size() > 0) ? obs_mask[0] : 16'h0);
        end
        n_checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 31'h0010_0A00 || obs_addr[1] !== 31'h0010_0A04) begin
            n_fail++;
            $display("FAIL rect_addr: got %0d addrs, first=%h, required 00100a00,00100a04",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 31'h0);
        end
        n_checks++;
        if (obs_data.size() == 0 || obs_data[0] !== {4{32'h0012_3456}}) begin
            n_fail++;
            $display("FAIL rect_data: got %h, required %h", (obs_data.size() > 0) ? obs_data[0] : 128'h0,
                     {4{32'h0012_3456}});
        end
        d = diff_count();
        n_checks++;
        if (d !== 0) begin n_fail++; $display("FAIL rect_model: %0d differences, required 0", d); end
        n_checks++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rect_done: %0d pulses, required 1", done_cnt - d0); end
    endtask

    task automatic test_full_width();
        int nz, d;
        clear_q();
        run_cmd("full", 0, 799, 0, 9, 1, 24'hA5C3E1);
        nz = 0;
        foreach (obs_mask[i]) if (obs_mask[i] !== 16'h0000) nz++;
        n_checks++;
        if (obs_addr.size() != 1000 || obs_data.size() != 2000 || nz != 0) begin
            n_fail++;
            $display("FAIL full_counts: af=%0d wdf=%0d masked=%0d, required 1000 2000 0",
                     obs_addr.size(), obs_data.size(), nz);
        end
        d = diff_count();
        n_checks++;
        if (d !== 0) begin n_fail++; $display("FAIL full_model: %0d differences, required 0", d); end
        clear_q();
        run_cmd("clampxy", 0, 1023, 590, 1023, 63, 24'h0F0F0F);
        n_checks++;
        if (obs_addr.size() != 1000 || obs_addr[obs_addr.size()-1] !== 31'((63 << 19) + (599 << 9) + (99 << 2))) begin
            n_fail++;
            $display("FAIL clampxy_last: af=%0d last=%h, required 1000 %h", obs_addr.size(),
                     (obs_addr.size() > 0) ? obs_addr[obs_addr.size()-1] : 31'h0,
                     31'((63 << 19) + (599 << 9) + (99 << 2)));
        end
        d = diff_count();
        n_checks++;
        if (d !== 0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL clampxy_model: %0d differences ready=%b, required 0 1", d, ready);
        end
    endtask

    task automatic test_empty_clip();
        int d0, d;
        clear_q(); d0 = done_cnt;
        issue(12, 4, 0, 0, 3, 24'h111111);
        n_checks++;
        if ({done, ready} !== 2'b00) begin n_fail++; $display("FAIL empty_check_cycle: done,ready=%b%b, required 00", done, ready); end
        @(posedge clk); #1;
        n_checks++;
        if ({done, ready} !== 2'b11) begin n_fail++; $display("FAIL empty_done: done,ready=%b%b, required 11", done, ready); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL empty_pulse: done=%b, required 0", done); end
        run_cmd("empty_y", 0, 20, 30, 10, 3, 24'h222222);
        run_cmd("empty_x", 900, 1000, 0, 0, 3, 24'h333333);
        n_checks++;
        if (obs_addr.size() + obs_data.size() != 0 || done_cnt - d0 != 3) begin
            n_fail++;
            $display("FAIL empty_pushes: pushes=%0d dones=%0d, required 0 3", obs_addr.size() + obs_data.size(), done_cnt - d0);
        end
        clear_q();
        run_cmd("clampx", 780, 1023, 3, 3, 7, 24'h445566);
        n_checks++;
        if (obs_mask.size() < 2 || obs_addr[obs_addr.size()-1][8:2] !== 7'd99 ||
            {obs_mask[obs_mask.size()-2], obs_mask[obs_mask.size()-1]} !== 32'h0) begin
            n_fail++;
            $display("FAIL clampx_last: words=%0d last_x=%0d, required last burst x=792 masks 0000",
                     obs_mask.size(), (obs_addr.size() > 0) ? 8 * obs_addr[obs_addr.size()-1][8:2] : 0);
        end
        d = diff_count();
        n_checks++;
        if (d !== 0) begin n_fail++; $display("FAIL clampx_model: %0d differences, required 0", d); end
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 12; i++) begin
            rx0[i] = int'($urandom_range(0, 830));
            rx1[i] = rx0[i] + int'($urandom_range(0, 50)) - 4;
            if (rx1[i] < 0) rx1[i] = 0;
            if (rx1[i] > 1023) rx1[i] = 1023;
            ry0[i] = int'($urandom_range(0, 603));
            ry1[i] = ry0[i] + int'($urandom_range(0, 3)) - (($urandom_range(0, 7) == 0) ? 2 : 0);
            if (ry1[i] < 0) ry1[i] = 0;
            rfid[i] = int'($urandom_range(0, 63));
            rcol[i] = 24'($urandom);
        end
        clear_q();
        for (int i = 0; i < 12; i++) run_cmd("random", rx0[i], rx1[i], ry0[i], ry1[i], rfid[i], rcol[i]);
        d = diff_count();
        n_checks++;
        if (d !== 0 || viol_pair !== 0) begin
            n_fail++; $display("FAIL random_model: %0d differences, %0d pairing errors, required 0 0", d, viol_pair);
        end
    endtask

    task automatic test_backpressure();
        int d;
        clear_q();
        bp_en = 1'b1;
        for (int i = 0; i < 12; i++) run_cmd("bp", rx0[i], rx1[i], ry0[i], ry1[i], rfid[i], rcol[i]);
        bp_en = 1'b0;
        d = diff_count();
        n_checks++;
        if (d !== 0) begin n_fail++; $display("FAIL bp_model: %0d differences, required 0", d); end
        n_checks++;
        if (viol_full !== 0) begin n_fail++; $display("FAIL bp_push_while_full: %0d, required 0", viol_full); end
        n_checks++;
        if (viol_stable !== 0) begin n_fail++; $display("FAIL bp_stall_stable: %0d changes, required 0", viol_stable); end
        n_checks++;
        if (viol_pair !== 0) begin n_fail++; $display("FAIL bp_burst_order: %0d, required 0", viol_pair); end
    endtask

    task automatic test_valid_held();
        int d0, d;
        clear_q(); d0 = done_cnt;
        while (ready !== 1'b1) @(negedge clk);
        valid = 1'b1; x0 = 10'd5; x1 = 10'd30; y0 = 10'd7; y1 = 10'd8; frame_id = 6'd9; color = 24'hABCDEF;
        @(posedge clk); #1;
        x0 = 10'd100; x1 = 10'd115; y0 = 10'd20; y1 = 10'd20; frame_id = 6'd4; color = 24'h13579B;
        wait_done("held_a");
        @(posedge clk); #1 valid = 1'b0;
        wait_done("held_b");
        @(negedge clk);
        model_cmd(5, 30, 7, 8, 9, 24'hABCDEF);
        model_cmd(100, 115, 20, 20, 4, 24'h13579B);
        d = diff_count();
        n_checks++;
        if (d !== 0 || done_cnt - d0 !== 2) begin
            n_fail++; $display("FAIL valid_held: %0d differences %0d dones, required 0 2", d, done_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        int n, d;
        clear_q();
        issue(0, 799, 0, 3, 5, 24'h777777);
        n = 0;
        do begin @(negedge clk); n++; end while (!(wdf_wr_en === 1'b1 && af_wr_en === 1'b0) && n < 50);
        n_checks++;
        if (n >= 50) begin n_fail++; $display("FAIL arst_reach_data2: no second-word push within %0d cycles", n); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ready, done, af_wr_en, wdf_wr_en, wdf_mask_din} !== {4'b1000, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL arst_outputs: got rdy/done/af/wdf/mask=%b%b%b%b/%h, required 1000/ffff",
                     ready, done, af_wr_en, wdf_wr_en, wdf_mask_din);
        end
        @(posedge clk); #1 rst = 1'b0;
        clear_q();
        run_cmd("arst_next", 5, 20, 40, 41, 6, 24'h00FF00);
        d = diff_count();
        n_checks++;
        if (d !== 0) begin n_fail++; $display("FAIL arst_next_cmd: %0d differences, required 0", d); end
    endtask

    initial begin
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_rect_example();
        test_full_width();
        test_empty_clip();
        test_random();
        test_backpressure();
        test_valid_held();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
